sar_result_collector: RTL

SAR_RESULT_COLLECTOR -- requirements
Module: sar_result_collector

---
 rtl/sar_pkg.sv | 29 ++
 rtl/sar_result_collector_if.sv | 30 +++
 rtl/sar_code_fifo.sv | 74 +++++++
 rtl/sar_result_collector.sv | 124 ++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR result collector: capture FSM states,
// code/strobe widths and the mapping from OUTEN strobe position to code bit.
package sar_pkg;

    localparam int unsigned SAR_BITS = 8;
    localparam int unsigned OUTEN_W  = 7;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_BITS,
        ST_LSB
    } state_t;

    typedef logic [SAR_BITS-1:0] code_t;
    typedef logic [OUTEN_W-1:0]  outen_t;
    typedef logic [IDX_W-1:0]    idx_t;

    // OUTEN[i] resolves code bit i+1; code bit 0 is taken in the strobe-free LSB cycle.
    function automatic idx_t code_bit(input idx_t idx);
        return IDX_W'(idx + IDX_W'(1));
    endfunction

    function automatic outen_t outen_onehot(input idx_t idx);
        return OUTEN_W'(1) << idx;
    endfunction

endpackage

// File: rtl/sar_result_collector_if.sv
// Sequencer/consumer-facing bundle of the SAR result collector.
interface sar_result_collector_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    import sar_pkg::*;

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             SAR_RESET;
    outen_t           OUTEN;
    logic             VCOMP;
    code_t            DOUT;
    logic             DVALID;
    logic             DREADY;
    logic [LVL_W-1:0] LEVEL;
    logic             BUSY;
    logic             OVERFLOW;
    logic             SEQ_ERR;

    modport master (
        output SAR_RESET, OUTEN, VCOMP, DREADY,
        input  DOUT, DVALID, LEVEL, BUSY, OVERFLOW, SEQ_ERR
    );

    modport slave (
        input  SAR_RESET, OUTEN, VCOMP, DREADY,
        output DOUT, DVALID, LEVEL, BUSY, OVERFLOW, SEQ_ERR
    );

endinterface

// File: rtl/sar_code_fifo.sv
// Code FIFO with a registered head word; the head register is kept equal to the
// oldest entry so DOUT never depends combinationally on the inputs.
module sar_code_fifo
    import sar_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = SAR_BITS,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [LVL_W-1:0] level,
    output logic             drop_c
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [LVL_W-1:0] level_n;
    logic [LVL_W-1:0] level_after_pop;
    logic [WIDTH-1:0] head_n;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // A full FIFO still accepts a push when the same edge frees a slot.
    always_comb begin
        full            = (level == LVL_W'(DEPTH));
        do_pop          = valid & pop;
        do_push         = push & (~full | do_pop);
        drop_c          = push & full & ~do_pop;
        rd_ptr_n        = rd_ptr + PTR_W'(do_pop);
        level_after_pop = level - LVL_W'(do_pop);
        level_n         = level_after_pop + LVL_W'(do_push);
        head_n          = head;
        if (level_n != '0) begin
            if (level_after_pop == '0) begin
                head_n = push_data;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_ptr_n;
            level  <= level_n;
            valid  <= (level_n != '0);
            head   <= head_n;
        end
    end

endmodule

// File: rtl/sar_result_collector.sv
// Assembles SAR bit decisions into 8-bit codes, checks the SAR_RESET/OUTEN
// sequence and buffers completed codes for a ready/valid consumer.
module sar_result_collector
    import sar_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                  CLK,
    input logic                  RESET,
    sar_result_collector_if.slave bus
);

    state_t state;
    state_t state_n;
    idx_t   idx;
    idx_t   idx_n;
    code_t  code;
    code_t  code_n;
    code_t  push_data;
    code_t  push_data_n;
    logic   push_q;
    logic   push_n;
    logic   err_set;
    logic   seq_err;
    logic   overflow;
    logic   busy;
    logic   drop_c;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            idx       <= '0;
            code      <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
            busy      <= 1'b0;
            seq_err   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            code      <= code_n;
            push_q    <= push_n;
            push_data <= push_data_n;
            busy      <= (state_n != ST_IDLE);
            if (err_set) seq_err  <= 1'b1;
            if (drop_c)  overflow <= 1'b1;
        end
    end

    // Capture FSM: one SAMPLE cycle, seven strobed bit cycles, one strobe-free LSB cycle.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        code_n      = code;
        push_n      = 1'b0;
        push_data_n = push_data;
        err_set     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.SAR_RESET) state_n = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.SAR_RESET) begin
                    state_n = ST_ARMED;
                end else if (bus.OUTEN == outen_onehot(IDX_W'(OUTEN_W - 1))) begin
                    code_n[SAR_BITS-1] = bus.VCOMP;
                    idx_n              = IDX_W'(OUTEN_W - 2);
                    state_n            = ST_BITS;
                end else begin
                    err_set = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_BITS: begin
                if (bus.SAR_RESET) begin
                    state_n = ST_ARMED;
                end else if (bus.OUTEN == outen_onehot(idx)) begin
                    code_n[code_bit(idx)] = bus.VCOMP;
                    if (idx == '0) begin
                        state_n = ST_LSB;
                    end else begin
                        idx_n = idx - IDX_W'(1);
                    end
                end else begin
                    err_set = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_LSB: begin
                if (!bus.SAR_RESET && bus.OUTEN == '0) begin
                    code_n[0]   = bus.VCOMP;
                    push_n      = 1'b1;
                    push_data_n = {code[SAR_BITS-1:1], bus.VCOMP};
                    state_n     = ST_IDLE;
                end else begin
                    err_set = 1'b1;
                    state_n = bus.SAR_RESET ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    sar_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAR_BITS)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (push_q),
        .push_data (push_data),
        .pop       (bus.DREADY),
        .head      (bus.DOUT),
        .valid     (bus.DVALID),
        .level     (bus.LEVEL),
        .drop_c    (drop_c)
    );

    assign bus.BUSY     = busy;
    assign bus.SEQ_ERR  = seq_err;
    assign bus.OVERFLOW = overflow;

endmodule
